pc_gen: RTL and testbench

PC_GEN -- requirements
Module: pc_gen

---
 rtl/pc_pkg.sv | 21 ++
 rtl/pc_ras.sv | 68 ++++++
 rtl/pc_gen.sv | 112 +++++++++++
 tb/tb_pc_gen.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared constants, PC-source encoding and alignment helper for the fetch PC generator.
package pc_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned STEP_C       = 2;
  localparam int unsigned STEP_W       = 4;

  typedef enum logic [2:0] {
    SEL_TRAP,
    SEL_REDIRECT,
    SEL_HOLD,
    SEL_POP,
    SEL_SEQ
  } pc_sel_e;

  // Mask that clears the bits below the fetch granule (bit 0 with compressed, bits 1:0 without).
  function automatic logic [63:0] align_mask(input logic c_ext);
    return c_ext ? ~64'd1 : ~64'd3;
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: a full push overwrites the oldest entry.
module pc_ras
  import pc_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = XLEN_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top_data,
  output logic         empty,
  output logic         full
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;

  always_comb begin
    mem_d = mem_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push && pop && (cnt_q != '0)) begin
      // Pop-then-push collapses to replacing the top in place.
      mem_d[ptr_q] = push_data;
    end else if (push) begin
      ptr_d        = ptr_q + 1'b1;
      mem_d[ptr_d] = push_data;
      if (cnt_q != DEPTH_CNT) cnt_d = cnt_q + 1'b1;
    end else if (pop && (cnt_q != '0)) begin
      ptr_d = ptr_q - 1'b1;
      cnt_d = cnt_q - 1'b1;
    end
    empty_d = (cnt_d == '0);
    full_d  = (cnt_d == DEPTH_CNT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      empty_q <= empty_d;
      full_q  <= full_d;
    end
  end

  assign top_data = mem_q[ptr_q];
  assign empty    = empty_q;
  assign full     = full_q;

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: trap > redirect > stall > RAS return > sequential step.
module pc_gen
  import pc_pkg::*;
#(
  parameter int unsigned XLEN      = XLEN_DEFAULT,
  parameter int unsigned RAS_DEPTH = 4,
  parameter int unsigned C_EXT     = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_start,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            is_call,
  input  logic            is_ret,
  input  logic            is_compressed,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_plus_step,
  output logic [XLEN-1:0] pc_next,
  output logic            misalign_err,
  output logic            ras_empty,
  output logic            ras_full
);

  localparam logic [63:0]     MASK64     = align_mask(C_EXT != 0);
  localparam logic [XLEN-1:0] ALIGN_MASK = MASK64[XLEN-1:0];

  logic [XLEN-1:0] pc_q, pc_d;
  logic            misalign_q, misalign_d;
  logic [XLEN-1:0] step;
  logic [XLEN-1:0] start_aligned;
  logic [XLEN-1:0] ras_top;
  logic            redirect_ok;
  logic            ras_push, ras_pop;
  pc_sel_e         sel;

  always_comb begin
    step          = ((C_EXT != 0) && is_compressed) ? XLEN'(STEP_C) : XLEN'(STEP_W);
    pc_plus_step  = pc_q + step;
    start_aligned = pc_start & ALIGN_MASK;
    redirect_ok   = ((redirect_pc & ~ALIGN_MASK) == '0);
  end

  always_comb begin
    sel        = SEL_SEQ;
    misalign_d = 1'b0;
    if (trap_valid) begin
      sel = SEL_TRAP;
    end else if (redirect_valid) begin
      sel        = redirect_ok ? SEL_REDIRECT : SEL_HOLD;
      misalign_d = !redirect_ok;
    end else if (stall) begin
      sel = SEL_HOLD;
    end else if (is_ret && !ras_empty) begin
      sel = SEL_POP;
    end
  end

  always_comb begin
    pc_d = pc_plus_step;
    unique case (sel)
      SEL_TRAP:     pc_d = trap_pc & ALIGN_MASK;
      SEL_REDIRECT: pc_d = redirect_pc;
      SEL_HOLD:     pc_d = pc_q;
      SEL_POP:      pc_d = ras_top;
      SEL_SEQ:      pc_d = pc_plus_step;
      default:      pc_d = pc_plus_step;
    endcase
    pc_next = rst ? start_aligned : pc_d;
  end

  // Predecode hints only act on a plain sequential cycle.
  always_comb begin
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    if (!rst && !trap_valid && !redirect_valid && !stall) begin
      ras_push = is_call;
      ras_pop  = is_ret && !ras_empty;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= start_aligned;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

  pc_ras #(
    .DEPTH (RAS_DEPTH),
    .W     (XLEN)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_plus_step),
    .top_data  (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

  assign pc_out       = pc_q;
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_pc_gen.sv
// Drives a compressed-capable and a word-only pc_gen with shared stimulus and checks both.
module tb_pc_gen;

  logic        clk;
  logic        rst;
  logic [31:0] pc_start;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        trap_valid;
  logic [31:0] trap_pc;
  logic        is_call;
  logic        is_ret;
  logic        is_compressed;

  logic [31:0] pc_out_c, pc_plus_c, pc_next_c;
  logic        err_c, empty_c, full_c;
  logic [31:0] pc_out_w, pc_plus_w, pc_next_w;
  logic        err_w, empty_w, full_w;

  int checks = 0;
  int errors = 0;

  // Reference state: index 0 = word-only instance, 1 = compressed instance.
  logic [31:0] m_pc   [2];
  logic        m_err  [2];
  logic [31:0] e_plus [2];
  logic [31:0] e_next [2];
  logic [31:0] q0[$];
  logic [31:0] q1[$];

  pc_gen #(.XLEN(32), .RAS_DEPTH(4), .C_EXT(1)) u_dut_c (
    .clk(clk), .rst(rst), .pc_start(pc_start), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .trap_valid(trap_valid), .trap_pc(trap_pc),
    .is_call(is_call), .is_ret(is_ret), .is_compressed(is_compressed),
    .pc_out(pc_out_c), .pc_plus_step(pc_plus_c), .pc_next(pc_next_c),
    .misalign_err(err_c), .ras_empty(empty_c), .ras_full(full_c)
  );

  pc_gen #(.XLEN(32), .RAS_DEPTH(4), .C_EXT(0)) u_dut_w (
    .clk(clk), .rst(rst), .pc_start(pc_start), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .trap_valid(trap_valid), .trap_pc(trap_pc),
    .is_call(is_call), .is_ret(is_ret), .is_compressed(is_compressed),
    .pc_out(pc_out_w), .pc_plus_step(pc_plus_w), .pc_next(pc_next_w),
    .misalign_err(err_w), .ras_empty(empty_w), .ras_full(full_w)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Architectural rules applied to the current inputs; advances the model by one edge.
  task automatic model_step(input int k);
    logic        cext;
    logic [31:0] mask;
    logic [31:0] plus;
    logic [31:0] nxt;
    logic        err;
    logic [31:0] q[$];
    cext = (k == 1);
    mask = cext ? 32'hFFFF_FFFE : 32'hFFFF_FFFC;
    if (k == 0) q = q0; else q = q1;
    plus = m_pc[k] + ((cext && is_compressed) ? 32'd2 : 32'd4);
    nxt  = m_pc[k];
    err  = 1'b0;
    if (rst) begin
      nxt = pc_start & mask;
      q.delete();
    end else if (trap_valid) begin
      nxt = trap_pc & mask;
    end else if (redirect_valid) begin
      if ((redirect_pc & ~mask) == 32'd0) nxt = redirect_pc;
      else err = 1'b1;
    end else if (!stall) begin
      nxt = plus;
      if (is_ret && q.size() > 0) nxt = q.pop_back();
      if (is_call) begin
        q.push_back(plus);
        if (q.size() > 4) void'(q.pop_front());
      end
    end
    e_plus[k] = plus;
    e_next[k] = nxt;
    m_pc[k]   = nxt;
    m_err[k]  = err;
    if (k == 0) q0 = q; else q1 = q;
  endtask

  // Inputs are already driven; check combinational outputs, take the edge, check registers.
  task automatic cycle();
    #1;
    model_step(0);
    model_step(1);
    chk("plus_w", pc_plus_w, e_plus[0]);
    chk("next_w", pc_next_w, e_next[0]);
    chk("plus_c", pc_plus_c, e_plus[1]);
    chk("next_c", pc_next_c, e_next[1]);
    @(posedge clk);
    #1;
    chk("pc_w",    pc_out_w, m_pc[0]);
    chk("err_w",   {31'd0, err_w},   {31'd0, m_err[0]});
    chk("empty_w", {31'd0, empty_w}, {31'd0, q0.size() == 0});
    chk("full_w",  {31'd0, full_w},  {31'd0, q0.size() == 4});
    chk("pc_c",    pc_out_c, m_pc[1]);
    chk("err_c",   {31'd0, err_c},   {31'd0, m_err[1]});
    chk("empty_c", {31'd0, empty_c}, {31'd0, q1.size() == 0});
    chk("full_c",  {31'd0, full_c},  {31'd0, q1.size() == 4});
  endtask

  task automatic idle();
    rst            = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    trap_valid     = 1'b0;
    trap_pc        = 32'd0;
    is_call        = 1'b0;
    is_ret         = 1'b0;
    is_compressed  = 1'b0;
  endtask

  task automatic do_reset(input logic [31:0] start);
    idle();
    rst      = 1'b1;
    pc_start = start;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    m_pc[0] = 32'd0; m_pc[1] = 32'd0;
    m_err[0] = 1'b0; m_err[1] = 1'b0;
    pc_start = 32'd0;
    idle();

    // Boot and plain sequential fetch.
    do_reset(32'h0000_1000);
    chk("boot_pc_w", pc_out_w, 32'h0000_1000);
    chk("boot_empty_w", {31'd0, empty_w}, 32'd1);
    cycle(); chk("seq1_w", pc_out_w, 32'h0000_1004);
    cycle(); chk("seq2_w", pc_out_w, 32'h0000_1008);
    cycle(); chk("seq3_w", pc_out_w, 32'h0000_100C);

    // Redirect outranks stall; misaligned redirect holds on the word-only instance.
    do_reset(32'h0000_1000);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_2000; stall = 1'b1;
    cycle(); chk("redir_w", pc_out_w, 32'h0000_2000);
    stall = 1'b0; redirect_pc = 32'h0000_2002;
    cycle();
    chk("misal_hold_w", pc_out_w, 32'h0000_2000);
    chk("misal_err_w", {31'd0, err_w}, 32'd1);
    chk("misal_ok_c", pc_out_c, 32'h0000_2002);
    idle();
    cycle(); chk("misal_pulse_w", {31'd0, err_w}, 32'd0);

    // Compressed call, redirect into callee, return.
    do_reset(32'h0000_1000);
    is_call = 1'b1; is_compressed = 1'b1;
    cycle();
    idle(); redirect_valid = 1'b1; redirect_pc = 32'h0000_3000;
    cycle();
    idle(); is_ret = 1'b1;
    cycle();
    chk("ret_pc_c", pc_out_c, 32'h0000_1002);
    chk("ret_empty_c", {31'd0, empty_c}, 32'd1);
    chk("ret_pc_w", pc_out_w, 32'h0000_1004);

    // Overflowing the stack keeps the newest four return addresses.
    do_reset(32'h0000_0100);
    for (int i = 1; i <= 5; i++) begin
      idle(); is_call = 1'b1;
      cycle();
      idle(); redirect_valid = 1'b1; redirect_pc = 32'(i + 1) << 8;
      cycle();
    end
    chk("ovf_full_c", {31'd0, full_c}, 32'd1);
    chk("ovf_full_w", {31'd0, full_w}, 32'd1);
    idle(); is_ret = 1'b1;
    for (int j = 0; j < 4; j++) begin
      cycle();
      chk("ovf_ret_c", pc_out_c, (32'(5 - j) << 8) + 32'd4);
    end
    cycle();
    chk("ovf_fall_c", pc_out_c, 32'h0000_0208);
    chk("ovf_empty_c", {31'd0, empty_c}, 32'd1);

    // Trap outranks a (misaligned) redirect and never flags an error.
    do_reset(32'h0000_1000);
    trap_valid = 1'b1; trap_pc = 32'h0000_8003;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_2002;
    cycle();
    chk("trap_pc_c", pc_out_c, 32'h0000_8002);
    chk("trap_pc_w", pc_out_w, 32'h0000_8000);
    chk("trap_err_c", {31'd0, err_c}, 32'd0);
    chk("trap_err_w", {31'd0, err_w}, 32'd0);

    // Address wrap.
    do_reset(32'hFFFF_FFFC);
    cycle();
    chk("wrap_c", pc_out_c, 32'h0000_0000);
    chk("wrap_w", pc_out_w, 32'h0000_0000);

    // Randomised mix against the reference model.
    do_reset(32'h0000_4000);
    for (int n = 0; n < 400; n++) begin
      rst            = ($urandom_range(0, 63) == 0);
      pc_start       = $urandom;
      trap_valid     = ($urandom_range(0, 15) == 0);
      trap_pc        = $urandom;
      redirect_valid = ($urandom_range(0, 7) == 0);
      redirect_pc    = ($urandom & 32'hFFFF_FFFC) |
                       (($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
      stall          = ($urandom_range(0, 7) == 0);
      is_call        = ($urandom_range(0, 3) == 0);
      is_ret         = ($urandom_range(0, 3) == 0);
      is_compressed  = $urandom_range(0, 1) == 1;
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
